ddr3_pad_responder: RTL and testbench

// - Device-side (DRAM-end) responder for the controller's DDR3 pad interface; bench/FPGA stand-in for a x16 DDR3 part.
// - Decodes pad_* commands, tracks open rows per bank, captures packed burst-8 write data and returns packed burst-8 read data.
// - The bidirectional pads are split into _in/_out/_oe; the top level or bench builds the tristates.

---
 rtl/ddr3_pad_responder.sv | 200 ++++++++++++++++++++
 tb/tb_ddr3_pad_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_pad_responder.sv
// Device-side DDR3 x16 stand-in: decodes pad commands, tracks open rows, stores and returns burst-8 data.
// Define RESP_BANK_CHECK_EN to enable bank-state/ODT protocol checking and closed-bank command drop.
module ddr3_pad_responder #(
  parameter int unsigned DQ_BITS      = 16,
  parameter int unsigned DQS_BITS     = 2,
  parameter int unsigned DM_BITS      = 2,
  parameter int unsigned BA_BITS      = 3,
  parameter int unsigned ADDR_BITS    = 14,
  parameter int unsigned ROW_IDX_BITS = 2,
  parameter int unsigned CL           = 5,
  parameter int unsigned CWL          = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pad_rst_n,
  input  logic                    pad_cke,
  input  logic                    pad_cs_n,
  input  logic                    pad_ras_n,
  input  logic                    pad_cas_n,
  input  logic                    pad_we_n,
  input  logic [BA_BITS-1:0]      pad_ba,
  input  logic [ADDR_BITS-1:0]    pad_addr,
  input  logic                    pad_odt,
  input  logic [DQ_BITS*8-1:0]    pad_dq_all_in,
  input  logic [DM_BITS*8-1:0]    pad_dm_all_in,
  output logic [DQ_BITS*8-1:0]    pad_dq_all_out,
  output logic                    pad_dq_all_oe,
  output logic [DQS_BITS-1:0]     pad_dqs_out,
  output logic [DQS_BITS-1:0]     pad_dqs_n_out,
  output logic                    err_protocol,
  output logic [15:0]             rd_count
);

  localparam int unsigned NumBanks  = 1 << BA_BITS;
  localparam int unsigned IdxBits   = BA_BITS + ROW_IDX_BITS + 7;
  localparam int unsigned MemDepth  = 1 << IdxBits;
  localparam int unsigned BurstBits = DQ_BITS * 8;
  localparam int unsigned MaskBits  = DM_BITS * 8;

  localparam logic [2:0] CmdMrs = 3'b000;
  localparam logic [2:0] CmdRef = 3'b001;
  localparam logic [2:0] CmdPre = 3'b010;
  localparam logic [2:0] CmdAct = 3'b011;
  localparam logic [2:0] CmdWr  = 3'b100;
  localparam logic [2:0] CmdRd  = 3'b101;

  logic [BurstBits-1:0] mem [MemDepth];

  logic [NumBanks-1:0]     open_q, open_d;
  logic [ROW_IDX_BITS-1:0] row_q [NumBanks];
  logic [ROW_IDX_BITS-1:0] row_d [NumBanks];
  logic [CL-1:0]           rd_vld_q, rd_vld_d;
  logic [IdxBits-1:0]      rd_idx_q [CL];
  logic [IdxBits-1:0]      rd_idx_d [CL];
  logic [CWL-1:0]          wr_vld_q, wr_vld_d;
  logic [IdxBits-1:0]      wr_idx_q [CWL];
  logic [IdxBits-1:0]      wr_idx_d [CWL];
  logic [BurstBits-1:0]    dq_out_q, dq_out_d;
  logic                    oe_q, oe_d;
  logic [DQS_BITS-1:0]     dqs_q, dqs_d;
  logic [DQS_BITS-1:0]     dqs_n_q, dqs_n_d;
  logic                    err_q, err_d;
  logic [15:0]             rd_cnt_q, rd_cnt_d;

  logic                    cmd_take;
  logic [2:0]              cmd;
  logic                    is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
  logic                    bank_open;
  logic [ROW_IDX_BITS-1:0] cmd_row;
  logic [IdxBits-1:0]      cmd_idx;
  logic                    rd_issue, wr_issue;
  logic                    rd_ret, wr_commit;
  logic                    chk_err;
  logic                    unused_pads;

  assign cmd_take  = pad_cke && !pad_cs_n;
  assign cmd       = {pad_ras_n, pad_cas_n, pad_we_n};
  assign is_act    = cmd_take && (cmd == CmdAct);
  assign is_rd     = cmd_take && (cmd == CmdRd);
  assign is_wr     = cmd_take && (cmd == CmdWr);
  assign is_pre    = cmd_take && (cmd == CmdPre);
  assign is_ref    = cmd_take && (cmd == CmdRef);
  assign is_mrs    = cmd_take && (cmd == CmdMrs);
  assign bank_open = open_q[pad_ba];
  assign cmd_row   = bank_open ? row_q[pad_ba] : '0;
  assign cmd_idx   = {pad_ba, cmd_row, pad_addr[9:3]};
  assign rd_ret    = rd_vld_q[CL-1];
  assign wr_commit = wr_vld_q[CWL-1];
  // Only a handful of address bits and MRS are decoded; the rest are don't-care here.
  assign unused_pads = ^{pad_addr, pad_odt, is_mrs};

`ifdef RESP_BANK_CHECK_EN
  assign rd_issue = is_rd && bank_open;
  assign wr_issue = is_wr && bank_open;
  assign chk_err  = ((is_rd || is_wr) && !bank_open) || (is_act && bank_open) ||
                    (is_ref && (|open_q)) || (wr_commit && !pad_odt);
`else
  assign rd_issue = is_rd;
  assign wr_issue = is_wr;
  assign chk_err  = 1'b0;
`endif

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (is_act) begin
      open_d[pad_ba] = 1'b1;
      row_d[pad_ba]  = pad_addr[ROW_IDX_BITS-1:0];
    end
    if (is_pre) begin
      if (pad_addr[10]) open_d = '0;
      else              open_d[pad_ba] = 1'b0;
    end

    rd_vld_d    = '0;
    rd_vld_d[0] = rd_issue;
    rd_idx_d    = rd_idx_q;
    rd_idx_d[0] = cmd_idx;
    for (int unsigned i = 1; i < CL; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_idx_d[i] = rd_idx_q[i-1];
    end
    wr_vld_d    = '0;
    wr_vld_d[0] = wr_issue;
    wr_idx_d    = wr_idx_q;
    wr_idx_d[0] = cmd_idx;
    for (int unsigned i = 1; i < CWL; i++) begin
      wr_vld_d[i] = wr_vld_q[i-1];
      wr_idx_d[i] = wr_idx_q[i-1];
    end

    // Nonblocking memory write means a colliding read sees the pre-write data.
    oe_d     = rd_ret;
    dq_out_d = rd_ret ? mem[rd_idx_q[CL-1]] : '0;
    dqs_d    = rd_ret ? '1 : '0;
    dqs_n_d  = rd_ret ? '0 : '1;
    rd_cnt_d = rd_cnt_q + {15'd0, rd_ret};
    err_d    = err_q | (rd_ret & wr_commit) | chk_err;

    // DDR3 RESET# clears device state but leaves the sticky flag and counter alone.
    if (!pad_rst_n) begin
      open_d   = '0;
      rd_vld_d = '0;
      wr_vld_d = '0;
      oe_d     = 1'b0;
      dq_out_d = '0;
      dqs_d    = '0;
      dqs_n_d  = '1;
      rd_cnt_d = rd_cnt_q;
      err_d    = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q   <= '0;
      rd_vld_q <= '0;
      wr_vld_q <= '0;
      for (int unsigned i = 0; i < NumBanks; i++) row_q[i] <= '0;
      for (int unsigned i = 0; i < CL; i++)       rd_idx_q[i] <= '0;
      for (int unsigned i = 0; i < CWL; i++)      wr_idx_q[i] <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      dqs_q    <= '0;
      dqs_n_q  <= '1;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
    end else begin
      open_q   <= open_d;
      row_q    <= row_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
      wr_vld_q <= wr_vld_d;
      wr_idx_q <= wr_idx_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      dqs_q    <= dqs_d;
      dqs_n_q  <= dqs_n_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Storage is deliberately not reset; masked bytes keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_commit && pad_rst_n && rst_n) begin
      for (int b = 0; b < int'(MaskBits); b++) begin
        if (!pad_dm_all_in[b]) mem[wr_idx_q[CWL-1]][b*8 +: 8] <= pad_dq_all_in[b*8 +: 8];
      end
    end
  end

  assign pad_dq_all_out = dq_out_q;
  assign pad_dq_all_oe  = oe_q;
  assign pad_dqs_out    = dqs_q;
  assign pad_dqs_n_out  = dqs_n_q;
  assign err_protocol   = err_q;
  assign rd_count       = rd_cnt_q;

endmodule

// File: tb/tb_ddr3_pad_responder.sv
// Directed self-checking bench for ddr3_pad_responder (default parameters, CL = CWL = 5).
module tb_ddr3_pad_responder;

  localparam int unsigned CL  = 5;
  localparam int unsigned CWL = 5;

  localparam logic [2:0] Act = 3'b011;
  localparam logic [2:0] Rd  = 3'b101;
  localparam logic [2:0] Wr  = 3'b100;
  localparam logic [2:0] Pre = 3'b010;
  localparam logic [2:0] Nop = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pad_rst_n;
  logic         pad_cke;
  logic         pad_cs_n;
  logic         pad_ras_n;
  logic         pad_cas_n;
  logic         pad_we_n;
  logic [2:0]   pad_ba;
  logic [13:0]  pad_addr;
  logic         pad_odt;
  logic [127:0] pad_dq_all_in;
  logic [15:0]  pad_dm_all_in;
  logic [127:0] pad_dq_all_out;
  logic         pad_dq_all_oe;
  logic [1:0]   pad_dqs_out;
  logic [1:0]   pad_dqs_n_out;
  logic         err_protocol;
  logic [15:0]  rd_count;

  int checks = 0;
  int errors = 0;

  logic [15:0]  exp_cnt;
  logic         exp_err;
  logic [127:0] d1;
  logic [127:0] d2;
  logic [127:0] exp_data [4];

  always #5 clk = ~clk;

  ddr3_pad_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pad_rst_n      (pad_rst_n),
    .pad_cke        (pad_cke),
    .pad_cs_n       (pad_cs_n),
    .pad_ras_n      (pad_ras_n),
    .pad_cas_n      (pad_cas_n),
    .pad_we_n       (pad_we_n),
    .pad_ba         (pad_ba),
    .pad_addr       (pad_addr),
    .pad_odt        (pad_odt),
    .pad_dq_all_in  (pad_dq_all_in),
    .pad_dm_all_in  (pad_dm_all_in),
    .pad_dq_all_out (pad_dq_all_out),
    .pad_dq_all_oe  (pad_dq_all_oe),
    .pad_dqs_out    (pad_dqs_out),
    .pad_dqs_n_out  (pad_dqs_n_out),
    .err_protocol   (err_protocol),
    .rd_count       (rd_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] ba, input logic [13:0] addr);
    {pad_ras_n, pad_cas_n, pad_we_n} = c;
    pad_ba   = ba;
    pad_addr = addr;
    @(posedge clk);
    #1;
    {pad_ras_n, pad_cas_n, pad_we_n} = Nop;
  endtask

  task automatic check_read(input string tag, input logic [127:0] data);
    check({tag, "_oe"}, {127'd0, pad_dq_all_oe}, 128'd1);
    check({tag, "_dq"}, pad_dq_all_out, data);
    check({tag, "_dqs"}, {126'd0, pad_dqs_out}, 128'd3);
    check({tag, "_dqsn"}, {126'd0, pad_dqs_n_out}, 128'd0);
  endtask

  initial begin
    rst_n = 1'b0; pad_rst_n = 1'b1; pad_cke = 1'b1; pad_cs_n = 1'b0;
    {pad_ras_n, pad_cas_n, pad_we_n} = Nop;
    pad_ba = '0; pad_addr = '0; pad_odt = 1'b1;
    pad_dq_all_in = '0; pad_dm_all_in = '0;
    exp_cnt = 16'd0; exp_err = 1'b0;
    d1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    d2 = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;

    tick(2);
    check("rst_oe", {127'd0, pad_dq_all_oe}, 128'd0);
    check("rst_dq", pad_dq_all_out, 128'd0);
    check("rst_dqs", {126'd0, pad_dqs_out}, 128'd0);
    check("rst_dqsn", {126'd0, pad_dqs_n_out}, 128'd3);
    check("rst_err", {127'd0, err_protocol}, 128'd0);
    check("rst_cnt", {112'd0, rd_count}, 128'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic write then read, exact CL latency.
    issue(Act, 3'd0, 14'd1);
    pad_dq_all_in = d1;
    issue(Wr, 3'd0, 14'd0);
    tick(CWL);
    issue(Rd, 3'd0, 14'd0);
    tick(CL - 1);
    check("early_oe", {127'd0, pad_dq_all_oe}, 128'd0);
    tick(1);
    exp_cnt++;
    check_read("rd1", d1);
    check("rd1_cnt", {112'd0, rd_count}, {112'd0, exp_cnt});
    tick(1);
    check("idle_oe", {127'd0, pad_dq_all_oe}, 128'd0);
    check("idle_dq", pad_dq_all_out, 128'd0);
    check("idle_dqsn", {126'd0, pad_dqs_n_out}, 128'd3);

    // Byte 0 masked.
    pad_dq_all_in = d2;
    pad_dm_all_in = 16'h0001;
    issue(Wr, 3'd0, 14'd0);
    tick(CWL);
    pad_dm_all_in = 16'h0000;
    exp_data[0] = {d2[127:8], d1[7:0]};
    issue(Rd, 3'd0, 14'd0);
    tick(CL);
    exp_cnt++;
    check_read("mask", exp_data[0]);

    // Fill cols 8/16/24, then four back-to-back reads.
    for (int i = 1; i < 4; i++) begin
      exp_data[i]   = {4{32'hA500_0000 + 32'(i)}};
      pad_dq_all_in = exp_data[i];
      issue(Wr, 3'd0, 14'(i * 8));
      tick(CWL);
    end
    for (int i = 0; i < 4; i++) begin
      {pad_ras_n, pad_cas_n, pad_we_n} = Rd;
      pad_ba   = 3'd0;
      pad_addr = 14'(i * 8);
      @(posedge clk);
      #1;
    end
    {pad_ras_n, pad_cas_n, pad_we_n} = Nop;
    tick(CL - 3);
    for (int i = 0; i < 4; i++) begin
      check_read($sformatf("b2b%0d", i), exp_data[i]);
      exp_cnt++;
      tick(1);
    end
    check("b2b_end_oe", {127'd0, pad_dq_all_oe}, 128'd0);
    check("b2b_cnt", {112'd0, rd_count}, {112'd0, exp_cnt});

    // Precharge all, then read a closed bank.
    issue(Pre, 3'd0, 14'h0400);
    issue(Rd, 3'd2, 14'd0);
`ifdef RESP_BANK_CHECK_EN
    exp_err = 1'b1;
    check("closed_err", {127'd0, err_protocol}, 128'd1);
    tick(CL);
    check("closed_oe", {127'd0, pad_dq_all_oe}, 128'd0);
`else
    tick(CL);
    exp_cnt++;
    check("closed_oe", {127'd0, pad_dq_all_oe}, 128'd1);
    check("closed_err", {127'd0, err_protocol}, 128'd0);
`endif
    check("closed_cnt", {112'd0, rd_count}, {112'd0, exp_cnt});

    // CKE low: read ignored.
    issue(Act, 3'd0, 14'd1);
    pad_cke = 1'b0;
    issue(Rd, 3'd0, 14'd0);
    pad_cke = 1'b1;
    tick(CL);
    check("cke_oe", {127'd0, pad_dq_all_oe}, 128'd0);
    check("cke_cnt", {112'd0, rd_count}, {112'd0, exp_cnt});

    // pad_rst_n mid-pipe cancels the read and closes banks, keeps err/count.
    issue(Rd, 3'd0, 14'd0);
    tick(2);
    pad_rst_n = 1'b0;
    tick(1);
    pad_rst_n = 1'b1;
    tick(CL - 3);
    check("prst_oe", {127'd0, pad_dq_all_oe}, 128'd0);
    check("prst_cnt", {112'd0, rd_count}, {112'd0, exp_cnt});
    check("prst_err", {127'd0, err_protocol}, {127'd0, exp_err});
    issue(Rd, 3'd0, 14'd0);
    tick(CL);
`ifdef RESP_BANK_CHECK_EN
    check("prst_closed_oe", {127'd0, pad_dq_all_oe}, 128'd0);
`else
    check("prst_closed_oe", {127'd0, pad_dq_all_oe}, 128'd1);
`endif

    // Async reset while a read is on the pads.
    issue(Act, 3'd0, 14'd1);
    issue(Rd, 3'd0, 14'd0);
    tick(CL);
    check("pre_arst_dq", pad_dq_all_out, exp_data[0]);
    rst_n = 1'b0;
    #1;
    check("arst_oe", {127'd0, pad_dq_all_oe}, 128'd0);
    check("arst_dq", pad_dq_all_out, 128'd0);
    check("arst_dqs", {126'd0, pad_dqs_out}, 128'd0);
    check("arst_dqsn", {126'd0, pad_dqs_n_out}, 128'd3);
    check("arst_err", {127'd0, err_protocol}, 128'd0);
    check("arst_cnt", {112'd0, rd_count}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // 65535 reads then one more wraps the counter.
    issue(Act, 3'd0, 14'd1);
    {pad_ras_n, pad_cas_n, pad_we_n} = Rd;
    pad_ba   = 3'd0;
    pad_addr = 14'd0;
    repeat (65535) @(posedge clk);
    #1;
    {pad_ras_n, pad_cas_n, pad_we_n} = Nop;
    tick(CL);
    check("cnt_max", {112'd0, rd_count}, {112'd0, 16'hFFFF});
    issue(Rd, 3'd0, 14'd0);
    tick(CL);
    check("wrap_oe", {127'd0, pad_dq_all_oe}, 128'd1);
    check("wrap_cnt", {112'd0, rd_count}, 128'd0);
    check("wrap_dq", pad_dq_all_out, exp_data[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
